// File: rtl/sequence_word_packer.sv
// sequence_word_packer: serial-in, parallel-out packer with a running 4-bit
// pattern detector and a two-entry output holding buffer.
// Configuration macro: SEQ_PACKER_OVERLAP_EN (defined = overlapping detection,
// undefined = non-overlapping detection, where a match restarts the history).
module sequence_word_packer (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out_word,
  output logic [7:0] out_mask,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);

  localparam int unsigned WORD_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [3:0]  PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-2:0]   sr_word;
  logic [WORD_W-2:0]   sr_mask;
  logic [2:0]          hist;
  logic [1:0]          hist_cnt;
  logic [WORD_W-1:0]   pend_word;
  logic [WORD_W-1:0]   pend_mask;
  logic                pend_valid;

  logic                match_c;
  logic                complete_c;
  logic                accept_c;
  logic [WORD_W-1:0]   new_word_c;
  logic [WORD_W-1:0]   new_mask_c;
  logic [1:0]          hist_cnt_nxt_c;

  // Pattern match, word completion and next history count for the current bit
  always_comb begin
    match_c    = (hist_cnt == 2'd3) && ({hist, bit_in} == PATTERN);
    complete_c = bit_valid && (bit_cnt == CNT_W'(WORD_W - 1));
    accept_c   = out_valid && out_ready;
    new_word_c = {sr_word, bit_in};
    new_mask_c = {sr_mask, match_c};
    hist_cnt_nxt_c = (hist_cnt == 2'd3) ? 2'd3 : hist_cnt + 2'd1;
`ifdef SEQ_PACKER_OVERLAP_EN
    // Overlapping: the suffix of a match may begin the next match
`else
    // Non-overlapping: a match needs four fresh bits before the next one
    if (match_c) begin
      hist_cnt_nxt_c = 2'd0;
    end
`endif
  end

  // Serial shift path and detector history; frozen on bit_valid=0
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= '0;
      sr_word  <= '0;
      sr_mask  <= '0;
      hist     <= '0;
      hist_cnt <= '0;
    end else if (bit_valid) begin
      bit_cnt  <= bit_cnt + CNT_W'(1);
      sr_word  <= new_word_c[WORD_W-2:0];
      sr_mask  <= new_mask_c[WORD_W-2:0];
      hist     <= {hist[1:0], bit_in};
      hist_cnt <= hist_cnt_nxt_c;
    end
  end

  // Two-entry holding buffer FSM with registered outputs and sticky overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      out_word   <= '0;
      out_mask   <= '0;
      out_valid  <= 1'b0;
      pend_word  <= '0;
      pend_mask  <= '0;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete_c) begin
            out_word  <= new_word_c;
            out_mask  <= new_mask_c;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept_c && complete_c) begin
            out_word <= new_word_c;
            out_mask <= new_mask_c;
          end else if (accept_c) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end else if (complete_c) begin
            pend_word  <= new_word_c;
            pend_mask  <= new_mask_c;
            pend_valid <= 1'b1;
            state      <= TWO;
          end
        end
        TWO: begin
          if (accept_c) begin
            out_word <= pend_word;
            out_mask <= pend_mask;
            if (complete_c) begin
              pend_word <= new_word_c;
              pend_mask <= new_mask_c;
            end else begin
              pend_valid <= 1'b0;
              state      <= ONE;
            end
          end else if (complete_c) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          out_valid  <= 1'b0;
          pend_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_word_packer.sv
// Directed self-checking bench for sequence_word_packer.
// Honours SEQ_PACKER_OVERLAP_EN for the expected mask of the overlap vector.
module tb_sequence_word_packer;

  logic       clk;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] out_word;
  logic [7:0] out_mask;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

`ifdef SEQ_PACKER_OVERLAP_EN
  localparam logic [7:0] EXP_B6_MASK = 8'h12;
`else
  localparam logic [7:0] EXP_B6_MASK = 8'h10;
`endif

  logic [15:0] rx_q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_out   = '0;

  sequence_word_packer dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .out_word  (out_word),
    .out_mask  (out_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Record transfers and check output stability across stalls
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_stable", {16'h0, out_word, out_mask}, {16'h0, prev_out});
      if (out_valid && out_ready) rx_q.push_back({out_word, out_mask});
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_word, out_mask};
    end
  end

  task automatic send_bit(input logic b, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bit_valid = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit gaps);
    for (int i = 7; i >= 0; i--) send_bit(w[i], gaps);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    if (idx < rx_q.size()) return {16'h0, rx_q[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    logic [7:0] first_bits;
    reset = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_word",     {24'h0, out_word}, 32'h0);
    check("rst_mask",     {24'h0, out_mask}, 32'h0);
    check("rst_valid",    {31'h0, out_valid}, 32'h0);
    check("rst_overflow", {31'h0, overflow},  32'h0);
    reset = 1'b0;

    // Single word with one match
    rx_q.delete();
    out_ready = 1'b1;
    send_word(8'hB0, 1'b0);
    drain();
    check("t1_count", 32'(rx_q.size()), 32'd1);
    check("t1_xfer",  rx_at(0), 32'h0000_B010);

    // Overlap-dependent mask
    rx_q.delete();
    send_word(8'hB6, 1'b0);
    drain();
    check("t2_count", 32'(rx_q.size()), 32'd1);
    check("t2_xfer",  rx_at(0), {16'h0, 8'hB6, EXP_B6_MASK});

    // Pattern spanning a word boundary
    rx_q.delete();
    send_word(8'h05, 1'b0);
    send_word(8'h80, 1'b0);
    drain();
    check("t3_count", 32'(rx_q.size()), 32'd2);
    check("t3_word1", rx_at(0), 32'h0000_0500);
    check("t3_word2", rx_at(1), 32'h0000_8080);

    // Overflow with a stalled consumer
    rx_q.delete();
    out_ready = 1'b0;
    send_word(8'h11, 1'b0);
    check("t4_valid_one", {31'h0, out_valid}, 32'h1);
    send_word(8'h22, 1'b0);
    check("t4_ovf_before", {31'h0, overflow}, 32'h0);
    send_word(8'h33, 1'b0);
    check("t4_ovf_set", {31'h0, overflow}, 32'h1);
    check("t4_head", {24'h0, out_word}, 32'h11);
    drain();
    check("t4_count", 32'(rx_q.size()), 32'd2);
    check("t4_first",  rx_at(0) >> 8, 32'h11);
    check("t4_second", rx_at(1) >> 8, 32'h22);
    check("t4_ovf_sticky", {31'h0, overflow}, 32'h1);

    // Reset mid-word discards partial state
    rx_q.delete();
    out_ready = 1'b0;
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    pulse_reset();
    check("t5_valid_rst", {31'h0, out_valid}, 32'h0);
    check("t5_ovf_rst",   {31'h0, overflow},  32'h0);
    first_bits = 8'hB0;
    for (int i = 7; i >= 0; i--) begin
      send_bit(first_bits[i], 1'b0);
      if (i > 0) check("t5_valid_early", {31'h0, out_valid}, 32'h0);
    end
    check("t5_valid", {31'h0, out_valid}, 32'h1);
    check("t5_word",  {24'h0, out_word},  32'hB0);
    check("t5_mask",  {24'h0, out_mask},  32'h10);
    check("t5_ovf",   {31'h0, overflow},  32'h0);
    drain();
    check("t5_count", 32'(rx_q.size()), 32'd1);

    // Random gaps and consumer stalls
    pulse_reset();
    rx_q.delete();
    send_word(8'hB0, 1'b1);
    send_word(8'hB6, 1'b1);
    drain();
    check("t6_count", 32'(rx_q.size()), 32'd2);
    check("t6_first",  rx_at(0), 32'h0000_B010);
    check("t6_second", rx_at(1), {16'h0, 8'hB6, EXP_B6_MASK});
    check("t6_ovf", {31'h0, overflow}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_word_packer.md
# sequence_word_packer

Serial-in, parallel-out packer with inline pattern detection: the receive-side counterpart of the word-to-serial sequence detector front end. It accepts one qualified bit per cycle, MSB first, and runs a 4-bit pattern detector continuously across the stream. Each 8 bits form a data word plus an 8-bit per-bit match mask, which it presents on a valid/ready output. A two-entry holding buffer absorbs consumer stalls; a sticky flag reports dropped words.

## Interface
- PATTERN, 4'b1011: pattern to detect, oldest bit in PATTERN[3].
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in qualifier; the bit is consumed on a posedge where bit_valid=1. There is no backpressure on this side.
- out_word  output  8  packed word; the first received bit is out_word[7].
- out_mask  output  8  out_mask[i]=1 iff the bit at out_word[i] completed a PATTERN match.
- out_valid  output  1  out_word/out_mask are valid.
- out_ready  input  1  consumer accepts; a transfer occurs on a posedge with out_valid & out_ready.
- overflow  output  1  sticky; set when a completed word is dropped.

## Operation
- State: bit_cnt (3 bits, 0..7), shift registers sr_word and sr_mask, 3-bit history hist, hist_cnt (saturating 0..3), output register (out_*, out_valid), pending register (pend_word, pend_mask, pend_valid).
- Per consumed bit:
  - match = (hist_cnt==3) && ({hist,bit_in}==PATTERN).
  - sr_word shifts in bit_in; sr_mask shifts in match.
  - hist <= {hist[1:0],bit_in}.
  - hist_cnt increments with saturation at 3, unless a match clears it (see Configuration).
- Detection is continuous. hist and hist_cnt are NOT reset at word boundaries, so a pattern may span two words; the match bit lands in the later word.
- Word completion: a consumed bit with bit_cnt==7. The completed word is {sr_word[6:0],bit_in} and mask {sr_mask[6:0],match}. bit_cnt wraps to 0.
- Buffer FSM, states EMPTY (out_valid=0), ONE (out_valid=1, pend_valid=0), TWO (both valid):
  - EMPTY + complete -> ONE; the word is loaded into the output register.
  - ONE + accept only -> EMPTY. ONE + complete only -> TWO; the word goes to pending. ONE + accept + complete -> ONE; the new word is loaded into the output register.
  - TWO + accept only -> ONE; pending moves to output. TWO + accept + complete -> TWO; pending moves to output and the new word goes to pending. TWO + complete without accept -> TWO; the new word is dropped and overflow <= 1.
- Words are delivered strictly in completion order.
- out_word/out_mask are stable while out_valid=1 and out_ready=0.
- overflow clears only on reset.

## Timing
- Reset values: out_word=0, out_mask=0, out_valid=0, overflow=0, bit_cnt=0, hist=0, hist_cnt=0, pend_valid=0.
- Reset mid-word discards all partial state, including bits already shifted in.
- Latency: the 8th bit is consumed at posedge N; out_valid=1 from just after posedge N, unless the FSM is in TWO with no accept.
- Throughput: one word per 8 consumed bits. The consumer may accept on the first valid cycle.
- bit_valid=0 cycles freeze bit_cnt, shift registers and history. The buffer FSM still services accepts.
- out_ready while out_valid=0 is ignored.

## Configuration
- SEQ_PACKER_OVERLAP_EN defined: overlapping detection. A match does not clear hist_cnt, so the suffix of a match can begin the next match.
- SEQ_PACKER_OVERLAP_EN undefined: non-overlapping detection. On a match, hist_cnt <= 0, so the next match needs 4 fresh bits after the matching bit.

## Test plan
- Reset, then bits 1,0,1,1,0,0,0,0 with out_ready=1 -> one transfer: out_word=8'hB0, out_mask=8'h10.
- Bits 1,0,1,1,0,1,1,0 -> out_word=8'hB6. Required mask: with SEQ_PACKER_OVERLAP_EN, out_mask=8'h12; without it, out_mask=8'h10.
- Cross-word match: word 8'h05 followed by first bit 1 of the next word (8'h80) -> word1 mask=8'h00, word2 mask=8'h80.
- out_ready=0 while words 8'h11, 8'h22, 8'h33 complete -> overflow=1 at the third completion. Then raise out_ready -> exactly two transfers, 8'h11 then 8'h22, and overflow remains 1.
- Assert reset after 4 bits of a word, then send 8'hB0 -> out_valid stays 0 until the new word completes, then out_word=8'hB0, out_mask=8'h10, overflow=0.
- Same stimulus as the first test with random bit_valid gaps and out_ready toggling -> identical transferred values, and out_* stable while stalled.
